// File: rtl/subtractor_16bit_serial_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int unsigned DEFAULT_WIDTH = 16;

  // Largest positive two's-complement value of width w, zero-extended to 64 bits.
  function automatic logic [63:0] max_pos(input int unsigned w);
    logic [63:0] v;
    v = '0;
    for (int unsigned i = 0; i < w - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Most negative two's-complement value of width w, zero-extended to 64 bits.
  function automatic logic [63:0] max_neg(input int unsigned w);
    logic [63:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/subtractor_16bit_serial_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface subtractor_16bit_serial_if
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             overflow;

  modport master (
    output start, A, B,
    input  busy, done, diff, overflow
  );

  modport slave (
    input  start, A, B,
    output busy, done, diff, overflow
  );
endinterface

// File: rtl/subtractor_16bit_serial_full_adder.sv
// Single-bit full adder cell shared by every bit position of the serial datapath.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  // Sum and carry of three input bits.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end
endmodule

// File: rtl/subtractor_16bit_serial.sv
// Bit-serial two's-complement subtractor: diff = A - B, LSB first, one bit per clock.
// Optional build macro SUBTRACTOR_SATURATE_EN clamps diff on signed overflow.
module subtractor_16bit_serial
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  subtractor_16bit_serial_if.slave           sub
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             a_msb, b_msb;
  logic [WIDTH-1:0] diff_q;
  logic             ovf_q;

  logic             fa_s, fa_c;
  logic             last_bit;
  logic [WIDTH-1:0] res_nxt;
  logic             ovf_nxt;
  logic [WIDTH-1:0] diff_nxt;

  full_adder_1bit u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Completed result and its signed-overflow flag, valid on the last RUN edge.
  always_comb begin
    last_bit = (cnt == LAST);
    res_nxt  = {fa_s, res[WIDTH-1:1]};
    ovf_nxt  = (a_msb != b_msb) && (fa_s != a_msb);
`ifdef SUBTRACTOR_SATURATE_EN
    diff_nxt = ovf_nxt ? (a_msb ? WIDTH'(max_neg(WIDTH)) : WIDTH'(max_pos(WIDTH))) : res_nxt;
`else
    diff_nxt = res_nxt;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sub.start) state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    sub.busy = (state == RUN);
    sub.done = (state == DONE);
  end

  // Serial datapath: operand capture, bit shifting and result commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff_q <= '0;
      ovf_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (sub.start) begin
        sa    <= sub.A;
        sb    <= ~sub.B;
        carry <= 1'b1;
        cnt   <= '0;
        a_msb <= sub.A[WIDTH-1];
        b_msb <= sub.B[WIDTH-1];
      end
    end else if (state == RUN) begin
      res   <= res_nxt;
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      carry <= fa_c;
      cnt   <= cnt + 1'b1;
      if (last_bit) begin
        diff_q <= diff_nxt;
        ovf_q  <= ovf_nxt;
      end
    end
  end

  assign sub.diff     = diff_q;
  assign sub.overflow = ovf_q;

endmodule

// File: tb/tb_subtractor_16bit_serial.sv
// Randomized self-checking bench for subtractor_16bit_serial against a signed-arithmetic model.
module tb_subtractor_16bit_serial;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  subtractor_16bit_serial_if #(.WIDTH(W)) bus ();

  subtractor_16bit_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sub   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic on the operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] d, output logic o);
    int sd;
    sd = int'($signed(a)) - int'($signed(b));
    o  = (sd > 32767) || (sd < -32768);
    d  = sd[W-1:0];
`ifdef SUBTRACTOR_SATURATE_EN
    if (o) d = (sd > 0) ? 16'h7FFF : 16'h8000;
`endif
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    logic [W-1:0] exp_d, prev_d;
    logic         exp_o, prev_o;
    int           cyc, n_busy;
    bit           changed;
    model(a, b, exp_d, exp_o);
    @(negedge clk);
    bus.start = 1'b1; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0; bus.A = W'($urandom); bus.B = W'($urandom);
    prev_d = bus.diff; prev_o = bus.overflow;
    cyc = 0; n_busy = 0; changed = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) n_busy++;
      if (bus.diff !== prev_d || bus.overflow !== prev_o) changed = 1;
      if (poke && cyc == 4) begin
        bus.start = 1'b1; bus.A = 16'd9; bus.B = 16'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check("latency", 32'(cyc), W);
    check("busy_cycles", 32'(n_busy), W);
    check("held_during_run", 32'(changed), 0);
    check("diff", 32'(bus.diff), 32'(exp_d));
    check("overflow", 32'(bus.overflow), 32'(exp_o));
    check("busy_in_done", 32'(bus.busy), 0);
    if (poke) begin
      bus.start = 1'b1; bus.A = 16'd9; bus.B = 16'd1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("done_one_cycle", 32'(bus.done), 0);
    if (poke) begin
      check("start_in_done_ignored", 32'(bus.busy), 0);
      @(negedge clk);
      check("no_second_done", 32'(bus.done), 0);
      check("diff_held_idle", 32'(bus.diff), 32'(exp_d));
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           n_done;
    bus.start = 1'b0; bus.A = '0; bus.B = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_diff", 32'(bus.diff), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    rst_n = 1'b1;

    run_op(16'd5, 16'd2, 0);
    run_op(16'hFFFE, 16'hFFFE, 0);
    run_op(16'h0002, 16'h0005, 0);
    run_op(16'h7FFF, 16'hFFFF, 0);
    run_op(16'h8000, 16'h0001, 0);
    run_op(16'd5, 16'd2, 1);
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      if (i % 5 == 0) ra[W-1] = ~rb[W-1];
      run_op(ra, rb, (i % 7 == 3));
    end

    // Abort an operation with reset; prior diff is nonzero so the clear is visible.
    run_op(16'h7FFF, 16'hFFFF, 0);
    @(negedge clk);
    bus.start = 1'b1; bus.A = 16'd100; bus.B = 16'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    check("mid_rst_diff", 32'(bus.diff), 0);
    check("mid_rst_ovf", 32'(bus.overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) n_done++;
    end
    check("no_done_after_abort", 32'(n_done), 0);
    run_op(16'd7, 16'd7, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/subtractor_16bit_serial.md
Name: subtractor_16bit_serial

Overview:
- Bit-serial two's-complement subtractor that computes diff = A - B, one bit per clock, LSB first, using a single full-adder cell.
- It is the inverse-operation companion to the team's combinational 16-bit adder, traded for minimum area.
- It uses a start/busy/done handshake and sits in the datapath beside the adder.
- Overflow reporting matches the adder's signed-overflow semantics.

Parameters:
- WIDTH, 16, operand/result width in bits (two's complement); must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend, signed; sampled on the accepting edge
- B  input  WIDTH  subtrahend, signed; sampled on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  result; held until the next completion
- overflow  output  1  signed overflow of A - B; held with diff

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, busy=0, done=0, diff=0, overflow=0.
  - Internal shift registers, bit counter and carry are cleared.
  - Reset asserted mid-operation aborts the operation immediately; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Latch A into sa and ~B into sb.
  - carry=1 (implements +1 of the two's complement); cnt=0.
  - Record a_msb=A[WIDTH-1] and b_msb=B[WIDTH-1].
  - -> RUN.
- RUN, each edge:
  - fa(sa[0], sb[0], carry) gives s and c.
  - Shift s into the result register MSB side; shift sa and sb right by 1; carry=c; cnt++.
  - On the edge where cnt==WIDTH-1 (edge k+WIDTH):
    - diff <= completed result.
    - overflow <= (a_msb != b_msb) && (result MSB != a_msb).
    - done <= 1; -> DONE.
- DONE: one cycle; done=1. At the next edge: done<=0, -> IDLE. start is ignored in DONE.
- Latency: done is high during the cycle after edge k+WIDTH, i.e. WIDTH cycles after acceptance. Maximum throughput is one operation per WIDTH+2 cycles.
- busy=1 exactly in RUN (WIDTH cycles).
- start while busy or in DONE is ignored, with no side effects on the in-flight operation. A and B may change freely after acceptance.
- diff and overflow change only on the completion edge. They are stable in IDLE, including while a new operation runs, until that operation's completion edge.
- Carry out of the MSB is discarded; only signed overflow is reported.
- Wrap-around: with overflow set and saturation off, diff is the modulo-2^WIDTH result.
- Width: WIDTH=16 gives a 4-bit counter. In general the counter is $clog2(WIDTH) bits.

Optional Feature:
- Macro: SUBTRACTOR_SATURATE_EN.
- Defined: when overflow=1 on completion, diff is clamped instead of wrapped.
  - a_msb=0 gives diff = 2^(WIDTH-1)-1 (0x7FFF).
  - a_msb=1 gives diff = -2^(WIDTH-1) (0x8000).
  - overflow is still reported as 1.
- Undefined: diff is the wrapped result. No saturation logic is synthesized.

Decomposition:
- Shared package subtractor_pkg:
  - state enum sub_state_t {IDLE, RUN, DONE}.
  - Localparam DEFAULT_WIDTH=16.
  - Saturation constants MAX_POS and MAX_NEG as functions of WIDTH.
- One sub-module, full_adder_1bit (a, b, cin -> s, cout), instantiated once in the serial datapath.
- Everything else lives in subtractor_16bit_serial.

Test Plan:
- Basic subtract: A=5, B=2, pulse start -> busy for 16 cycles, then done pulse with diff=0x0003, overflow=0.
- Negative operands: A=0xFFFE (-2), B=0xFFFE (-2) -> diff=0x0000, overflow=0. Next, A=0x0002, B=0x0005 -> diff=0xFFFD (-3), overflow=0.
- Positive overflow: A=0x7FFF, B=0xFFFF (-1) -> overflow=1.
  - diff=0x8000 without the macro.
  - diff=0x7FFF with SUBTRACTOR_SATURATE_EN.
- Negative overflow: A=0x8000, B=0x0001 -> overflow=1.
  - diff=0x7FFF without the macro.
  - diff=0x8000 with the macro.
- Handshake: start A=5, B=2; pulse start again with A=9, B=1 at cycle 4 and during DONE -> exactly one done, diff=0x0003. The prior diff is held until the completion edge.
- Reset mid-op: start A=100, B=1; deassert rst_n at cycle 8 for 2 cycles -> busy, done, diff and overflow go to 0 immediately and no done follows. A new start of 7-7 then completes with diff=0x0000 after 16 cycles.
